// File: rtl/game_pkg.sv
// Shared encodings, default parameter values and width helpers for the game-state sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PAUSE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_WIN   = 3'd4,
        ST_FAIL  = 3'd5
    } game_state_e;

    localparam int DEF_LEVELS         = 6;
    localparam int DEF_PHP_W          = 8;
    localparam int DEF_EHP_W          = 12;
    localparam int DEF_PLAYER_HP_INIT = 100;
    localparam int DEF_ENEMY_HP_BASE  = 1000;
    localparam int DEF_ENEMY_HP_STEP  = 500;
    localparam int DEF_TICK_DIV       = 416667;
    localparam int DEF_IFRAME_TICKS   = 60;

    // Level field width; a single-level game still gets a 1-bit field.
    function automatic int lvl_w(input int levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

    // Width of a counter holding values 0..n-1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Button/hit inputs and state/HP outputs between the game logic (master) and the sequencer (slave).
interface game_state_ctrl_if
    import game_pkg::*;
#(
    parameter int PHP_W = DEF_PHP_W,
    parameter int EHP_W = DEF_EHP_W,
    parameter int LVL_W = lvl_w(DEF_LEVELS)
);
    logic             enter;
    logic             pause;
    logic             player_hit;
    logic [PHP_W-1:0] player_dmg;
    logic             enemy_hit;
    logic [EHP_W-1:0] enemy_dmg;
    logic [2:0]       state;
    logic [LVL_W-1:0] level;
    logic [PHP_W-1:0] player_hp;
    logic [EHP_W-1:0] enemy_hp;
    logic             tick;
    logic             level_start;
    logic             invuln;

    modport master (
        output enter, pause, player_hit, player_dmg, enemy_hit, enemy_dmg,
        input  state, level, player_hp, enemy_hp, tick, level_start, invuln
    );

    modport slave (
        input  enter, pause, player_hit, player_dmg, enemy_hit, enemy_dmg,
        output state, level, player_hp, enemy_hp, tick, level_start, invuln
    );
endinterface

// File: rtl/game_state_ctrl_tick_gen.sv
// Game-tick divider: counts while run is high, emits a registered 1-cycle tick every TICK_DIV cycles.
module tick_gen
    import game_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int               CNT_W = cnt_w(TICK_DIV);
    localparam logic [CNT_W-1:0] TC    = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (run) begin
            if (r_cnt == TC) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-state sequencer: state, level, player/enemy HP and game tick for the bullet-hell top level.
// Optional invulnerability frames after a player hit are built when GAME_IFRAME_EN is defined.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int LEVELS         = DEF_LEVELS,
    parameter int PHP_W          = DEF_PHP_W,
    parameter int EHP_W          = DEF_EHP_W,
    parameter int PLAYER_HP_INIT = DEF_PLAYER_HP_INIT,
    parameter int ENEMY_HP_BASE  = DEF_ENEMY_HP_BASE,
    parameter int ENEMY_HP_STEP  = DEF_ENEMY_HP_STEP,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int IFRAME_TICKS   = DEF_IFRAME_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    game_state_ctrl_if.slave  bus
);
    //  state | meaning
    //  IDLE  | waiting for enter, values of the last game held
    //  PAUSE | play frozen: tick counter, HP and iframes held
    //  PLAY  | level running, hits applied, ticks generated
    //  CLEAR | enemy defeated, enter starts the next level
    //  WIN   | last level cleared, enter returns to IDLE
    //  FAIL  | player HP exhausted, enter returns to IDLE

    localparam int LVL_W = lvl_w(LEVELS);
    localparam longint EHP_MAX = longint'(ENEMY_HP_BASE) + longint'(ENEMY_HP_STEP) * longint'(LEVELS - 1);

    if (EHP_MAX >= (longint'(1) << EHP_W) || longint'(PLAYER_HP_INIT) >= (longint'(1) << PHP_W)
        || TICK_DIV < 2 || IFRAME_TICKS < 0) begin : g_param_err
        $fatal(1, "game_state_ctrl: HP values do not fit their widths or TICK_DIV < 2");
    end

    localparam logic [PHP_W-1:0] P_INIT   = PHP_W'(PLAYER_HP_INIT);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);

    function automatic logic [EHP_W-1:0] f_enemy_hp(input logic [LVL_W-1:0] lvl);
        longint v;
        v = longint'(ENEMY_HP_BASE) + longint'(ENEMY_HP_STEP) * longint'(lvl);
        return v[EHP_W-1:0];
    endfunction

    game_state_e      r_state;
    logic [LVL_W-1:0] r_level;
    logic [PHP_W-1:0] r_php;
    logic [EHP_W-1:0] r_ehp;
    logic             r_lstart;
    logic             r_enter_q;
    logic             r_pause_q;

    logic             w_enter_rise;
    logic             w_pause_rise;
    logic             w_invuln;
    logic             w_p_apply;
    logic [PHP_W-1:0] w_p_new;
    logic [EHP_W-1:0] w_e_new;
    logic             w_in_play;
    logic             w_stay_play;
    logic             w_start;
    logic             w_tick;

    assign w_enter_rise = bus.enter & ~r_enter_q;
    assign w_pause_rise = bus.pause & ~r_pause_q;
    assign w_p_apply    = bus.player_hit & ~w_invuln;

    // Saturating subtraction: damage larger than the remaining HP floors at zero.
    assign w_p_new = !w_p_apply ? r_php :
                     (r_php > bus.player_dmg) ? r_php - bus.player_dmg : '0;
    assign w_e_new = !bus.enemy_hit ? r_ehp :
                     (r_ehp > bus.enemy_dmg) ? r_ehp - bus.enemy_dmg : '0;

    assign w_in_play   = (r_state == ST_PLAY);
    assign w_stay_play = w_in_play && !w_pause_rise && (w_p_new != '0) && (w_e_new != '0);
    assign w_start     = w_enter_rise && ((r_state == ST_IDLE) || (r_state == ST_CLEAR));

    // Run only on edges that keep the game in PLAY so tick never lands in another state.
    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_stay_play),
        .clr   (w_start),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_level   <= '0;
            r_php     <= '0;
            r_ehp     <= '0;
            r_lstart  <= 1'b0;
            r_enter_q <= 1'b0;
            r_pause_q <= 1'b0;
        end else begin
            r_enter_q <= bus.enter;
            r_pause_q <= bus.pause;
            r_lstart  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_enter_rise) begin
                        r_state  <= ST_PLAY;
                        r_level  <= '0;
                        r_php    <= P_INIT;
                        r_ehp    <= f_enemy_hp('0);
                        r_lstart <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_pause_rise) begin
                        r_state <= ST_PAUSE;
                    end else begin
                        r_php <= w_p_new;
                        r_ehp <= w_e_new;
                        if (w_p_new == '0)
                            r_state <= ST_FAIL;
                        else if (w_e_new == '0)
                            r_state <= (r_level == LVL_LAST) ? ST_WIN : ST_CLEAR;
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_rise)
                        r_state <= ST_PLAY;
                end
                ST_CLEAR: begin
                    if (w_enter_rise) begin
                        r_state  <= ST_PLAY;
                        r_level  <= r_level + 1'b1;
                        r_php    <= P_INIT;
                        r_ehp    <= f_enemy_hp(r_level + 1'b1);
                        r_lstart <= 1'b1;
                    end
                end
                ST_WIN, ST_FAIL: begin
                    if (w_enter_rise)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef GAME_IFRAME_EN
    localparam int              IF_W    = cnt_w(IFRAME_TICKS + 1);
    localparam logic [IF_W-1:0] IF_LOAD = IF_W'(IFRAME_TICKS);

    logic            r_invuln;
    logic [IF_W-1:0] r_if_cnt;
    logic            w_keep;

    assign w_keep = (r_state == ST_PAUSE) || w_stay_play || (w_in_play && w_pause_rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_invuln <= 1'b0;
            r_if_cnt <= '0;
        end else if (w_start || !w_keep) begin
            r_invuln <= 1'b0;
            r_if_cnt <= '0;
        end else if (w_stay_play && w_p_apply) begin
            r_invuln <= 1'b1;
            r_if_cnt <= IF_LOAD;
        end else if (r_invuln && w_tick) begin
            if (r_if_cnt <= IF_W'(1)) begin
                r_invuln <= 1'b0;
                r_if_cnt <= '0;
            end else begin
                r_if_cnt <= r_if_cnt - 1'b1;
            end
        end
    end

    assign w_invuln = r_invuln;
`else
    assign w_invuln = 1'b0;
`endif

    assign bus.state       = r_state;
    assign bus.level       = r_level;
    assign bus.player_hp   = r_php;
    assign bus.enemy_hp    = r_ehp;
    assign bus.tick        = w_tick;
    assign bus.level_start = r_lstart;
    assign bus.invuln      = w_invuln;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: table-driven vectors through a scoreboard queue,
// plus hand sequences for tick timing, pause freeze, iframes and asynchronous reset.
module tb_game_state_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    game_state_ctrl_if #(.PHP_W(8), .EHP_W(12), .LVL_W(3)) bus ();

    game_state_ctrl #(
        .LEVELS(6), .PHP_W(8), .EHP_W(12), .PLAYER_HP_INIT(100),
        .ENEMY_HP_BASE(1000), .ENEMY_HP_STEP(500), .TICK_DIV(4), .IFRAME_TICKS(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        enter;
        logic        pause;
        logic        phit;
        logic [7:0]  pdmg;
        logic        ehit;
        logic [11:0] edmg;
        logic [2:0]  st;
        logic [2:0]  lvl;
        logic [7:0]  php;
        logic [11:0] ehp;
        logic        ls;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input int en, input int pa, input int ph, input int pd,
                                input int eh, input int ed, input int st, input int lv,
                                input int pp, input int ep, input int ls);
        vec_t v;
        v.enter = 1'(en);  v.pause = 1'(pa);
        v.phit  = 1'(ph);  v.pdmg  = 8'(pd);
        v.ehit  = 1'(eh);  v.edmg  = 12'(ed);
        v.st    = 3'(st);  v.lvl   = 3'(lv);
        v.php   = 8'(pp);  v.ehp   = 12'(ep);
        v.ls    = 1'(ls);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.enter = 1'b0; bus.pause = 1'b0;
        bus.player_hit = 1'b0; bus.player_dmg = '0;
        bus.enemy_hit = 1'b0; bus.enemy_dmg = '0;
    endtask

    // Counts edges until tick is seen; ok=0 if the budget runs out.
    task automatic wait_tick(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        int   cyc;
        bit   ok;
        int   nt;

        checks   = 0;
        failures = 0;
        idle_inputs();
        rst_n = 1'b0;

        #23;
        chk("rst_state",  64'(bus.state), 0);
        chk("rst_level",  64'(bus.level), 0);
        chk("rst_php",    64'(bus.player_hp), 0);
        chk("rst_ehp",    64'(bus.enemy_hp), 0);
        chk("rst_tick",   64'(bus.tick), 0);
        chk("rst_lstart", 64'(bus.level_start), 0);
        chk("rst_invuln", 64'(bus.invuln), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // enter rise, kill enemy, next level, enter ignored in PLAY, player damage
        vecs.push_back(mk(1,0,0,0,  0,0,    2,0,100,1000,1));
        vecs.push_back(mk(0,0,0,0,  0,0,    2,0,100,1000,0));
        vecs.push_back(mk(0,0,0,0,  1,300,  2,0,100,700,0));
        vecs.push_back(mk(0,0,0,0,  1,1200, 3,0,100,0,0));
        vecs.push_back(mk(1,0,0,0,  0,0,    2,1,100,1500,1));
        vecs.push_back(mk(0,0,0,0,  0,0,    2,1,100,1500,0));
        vecs.push_back(mk(1,0,0,0,  0,0,    2,1,100,1500,0));
        vecs.push_back(mk(0,0,0,0,  0,0,    2,1,100,1500,0));
        vecs.push_back(mk(0,0,1,60, 0,0,    2,1,40,1500,0));
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(0,0,0,0, 0,0, 2,1,40,1500,0));
        vecs.push_back(mk(0,0,1,60, 0,0,    5,1,0,1500,0));
        vecs.push_back(mk(0,0,1,60, 0,0,    5,1,0,1500,0));
        vecs.push_back(mk(1,0,0,0,  0,0,    0,1,0,1500,0));
        vecs.push_back(mk(0,0,0,0,  0,0,    0,1,0,1500,0));
        // pause behaviour: held level is not a rise, hits dropped on the pause-rise cycle
        vecs.push_back(mk(1,0,0,0,  0,0,    2,0,100,1000,1));
        vecs.push_back(mk(0,0,0,0,  0,0,    2,0,100,1000,0));
        vecs.push_back(mk(0,1,0,0,  0,0,    1,0,100,1000,0));
        vecs.push_back(mk(0,1,0,0,  1,500,  1,0,100,1000,0));
        vecs.push_back(mk(0,0,1,50, 0,0,    1,0,100,1000,0));
        vecs.push_back(mk(0,1,0,0,  0,0,    2,0,100,1000,0));
        vecs.push_back(mk(0,0,0,0,  0,0,    2,0,100,1000,0));
        vecs.push_back(mk(0,1,1,10, 1,100,  1,0,100,1000,0));
        vecs.push_back(mk(0,0,0,0,  0,0,    1,0,100,1000,0));
        vecs.push_back(mk(0,1,0,0,  0,0,    2,0,100,1000,0));
        vecs.push_back(mk(0,0,0,0,  0,0,    2,0,100,1000,0));
        // both HP reach zero in one cycle: FAIL wins
        vecs.push_back(mk(0,0,1,100,1,1000, 5,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,  0,0,    0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,    0,0,0,0,0));
        // run through every level to WIN
        vecs.push_back(mk(1,0,0,0,  0,0,    2,0,100,1000,1));
        for (int l = 0; l < 6; l++) begin
            vecs.push_back(mk(0,0,0,0, 1,4095, (l == 5) ? 4 : 3, l, 100, 0, 0));
            if (l < 5)
                vecs.push_back(mk(1,0,0,0, 0,0, 2, l+1, 100, 1000 + 500*(l+1), 1));
        end
        vecs.push_back(mk(1,0,0,0,  0,0,    0,5,100,0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,    0,5,100,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.enter      = vecs[i].enter;
            bus.pause      = vecs[i].pause;
            bus.player_hit = vecs[i].phit;
            bus.player_dmg = vecs[i].pdmg;
            bus.enemy_hit  = vecs[i].ehit;
            bus.enemy_dmg  = vecs[i].edmg;
            exp_q.push_back(vecs[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_state", i),  64'(bus.state),       64'(e.st));
            chk($sformatf("vec%0d_level", i),  64'(bus.level),       64'(e.lvl));
            chk($sformatf("vec%0d_php", i),    64'(bus.player_hp),   64'(e.php));
            chk($sformatf("vec%0d_ehp", i),    64'(bus.enemy_hp),    64'(e.ehp));
            chk($sformatf("vec%0d_lstart", i), 64'(bus.level_start), 64'(e.ls));
        end
        @(negedge clk);
        idle_inputs();

        // tick period from level start, freeze across a long pause, resume
        @(negedge clk); bus.enter = 1'b1;
        @(posedge clk); #1;
        chk("tick_start_state", 64'(bus.state), 2);
        @(negedge clk); bus.enter = 1'b0;
        wait_tick(20, cyc, ok);
        chk("tick_first_seen", 64'(ok), 1);
        chk("tick_first_delay", 64'(cyc), 4);
        wait_tick(20, cyc, ok);
        chk("tick_second_seen", 64'(ok), 1);
        chk("tick_period", 64'(cyc), 4);
        @(negedge clk); bus.pause = 1'b1;
        @(posedge clk); #1;
        chk("pause_state", 64'(bus.state), 1);
        nt = (bus.tick === 1'b1) ? 1 : 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus.tick === 1'b1) nt++;
        end
        chk("pause_no_tick", 64'(nt), 0);
        @(negedge clk); bus.pause = 1'b0;
        @(negedge clk); bus.pause = 1'b1;
        @(posedge clk); #1;
        chk("unpause_state", 64'(bus.state), 2);
        @(negedge clk); bus.pause = 1'b0;
        wait_tick(20, cyc, ok);
        chk("resume_seen", 64'(ok), 1);
        chk("resume_delay", 64'(cyc), 4);
        wait_tick(20, cyc, ok);
        chk("resume_period_seen", 64'(ok), 1);
        chk("resume_period", 64'(cyc), 4);

        // two player hits one cycle apart
        @(negedge clk); bus.player_hit = 1'b1; bus.player_dmg = 8'd10;
        @(posedge clk); #1;
        chk("ifr_first_php", 64'(bus.player_hp), 90);
`ifdef GAME_IFRAME_EN
        chk("ifr_invuln_set", 64'(bus.invuln), 1);
        nt = (bus.tick === 1'b1 && bus.invuln === 1'b1) ? 1 : 0;
`endif
        @(negedge clk); bus.player_hit = 1'b1; bus.player_dmg = 8'd10;
        @(posedge clk); #1;
        bus.player_hit = 1'b0;
`ifdef GAME_IFRAME_EN
        chk("ifr_second_ignored", 64'(bus.player_hp), 90);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.invuln !== 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.tick === 1'b1) nt++;
            @(posedge clk); #1;
        end
        chk("ifr_cleared", 64'(ok), 1);
        chk("ifr_ticks", 64'(nt), 2);
`else
        chk("nofr_second_applied", 64'(bus.player_hp), 80);
        chk("nofr_invuln", 64'(bus.invuln), 0);
`endif

        // asynchronous reset mid-game takes effect without a clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(bus.state), 0);
        chk("arst_level", 64'(bus.level), 0);
        chk("arst_php",   64'(bus.player_hp), 0);
        chk("arst_ehp",   64'(bus.enemy_hp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); bus.enter = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_start", 64'(bus.state), 2);
        chk("post_rst_ehp", 64'(bus.enemy_hp), 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
